popcount_expander: RTL



---
 rtl/popcount_expander_pkg.sv | 21 ++
 rtl/popcount_expander_nibble_fill.sv | 25 ++
 rtl/popcount_expander.sv | 101 ++++++++++
 3 files changed

// File: rtl/popcount_expander_pkg.sv
// Shared types and defaults for the popcount expander: state encoding,
// geometry constants and the clamp helper.
package popcount_expander_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NIB   = 4;
  localparam int unsigned CW    = 6;
  localparam int unsigned NIBS  = WIDTH / NIB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [CW-1:0] min_cw(input logic [CW-1:0] a,
                                           input logic [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/popcount_expander_nibble_fill.sv
// Combinational nibble stage: thermometer of min(remaining, NIB) ones,
// lowest index first, plus the number of ones used.
module nibble_fill
  import popcount_expander_pkg::*;
#(
  parameter int unsigned NIB = popcount_expander_pkg::NIB,
  parameter int unsigned CW  = popcount_expander_pkg::CW
) (
  input  logic [CW-1:0]  remaining,
  output logic [0:NIB-1] nib,
  output logic [2:0]     used
);

  logic [CW-1:0] n;

  always_comb begin
    n    = (remaining < CW'(NIB)) ? remaining : CW'(NIB);
    used = n[2:0];
    nib  = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      nib[i] = (CW'(i) < n);
    end
  end

endmodule

// File: rtl/popcount_expander.sv
// Builds a WIDTH-bit thermometer word holding in_count ones (clamped),
// one nibble per cycle with constant latency.
module popcount_expander
  import popcount_expander_pkg::*;
#(
  parameter int unsigned WIDTH = popcount_expander_pkg::WIDTH,
  parameter int unsigned NIB   = popcount_expander_pkg::NIB,
  parameter int unsigned CW    = popcount_expander_pkg::CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [CW-1:0]    in_count,
  output logic             in_ready,
  output logic             out_valid,
  output logic [0:WIDTH-1] out_word,
  output logic             out_sat,
  input  logic             out_ready
);

  localparam int unsigned NCNT = WIDTH / NIB;
  localparam int unsigned IW   = (NCNT > 1) ? $clog2(NCNT) : 1;
  localparam int unsigned AW   = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    remaining_q, remaining_d;
  logic [IW-1:0]    nib_idx_q, nib_idx_d;
  logic [0:WIDTH-1] out_word_q, out_word_d;
  logic             out_sat_q, out_sat_d;

  logic [0:NIB-1]   nib;
  logic [2:0]       used;
  logic [AW-1:0]    base;

  nibble_fill #(
    .NIB (NIB),
    .CW  (CW)
  ) u_nibble_fill (
    .remaining (remaining_q),
    .nib       (nib),
    .used      (used)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      nib_idx_q   <= '0;
      out_word_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      nib_idx_q   <= nib_idx_d;
      out_word_q  <= out_word_d;
      out_sat_q   <= out_sat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    nib_idx_d   = nib_idx_q;
    out_word_d  = out_word_q;
    out_sat_d   = out_sat_q;
    base        = AW'(nib_idx_q) * AW'(NIB);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          remaining_d = min_cw(in_count, CW'(WIDTH));
          out_sat_d   = (in_count > CW'(WIDTH));
          out_word_d  = '0;
          nib_idx_d   = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        // All nibbles are written even after remaining hits 0 so latency is fixed.
        out_word_d[base +: NIB] = nib;
        remaining_d             = remaining_q - CW'(used);
        nib_idx_d               = nib_idx_q + 1'b1;
        if (nib_idx_q == IW'(NCNT - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_word  = out_word_q;
  assign out_sat   = out_sat_q;

endmodule
